// File: rtl/fg_pkg.sv
// rtl/fg_pkg.sv - shared state encoding and default widths for the waveform sequencer
package fg_pkg;

  localparam int FG_COUNTER_BITWIDTH   = 32;
  localparam int FG_WAVEFORM_BITWIDTH  = 16;
  localparam int FG_PRESCALER_BITWIDTH = 8;
  localparam int FG_BURST_BITWIDTH     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fg_state_e;

endpackage

// File: rtl/fg_tick_prescaler.sv
// rtl/fg_tick_prescaler.sv - tick divider: one-cycle tick every divisor+1 enabled cycles
module fg_tick_prescaler
  import fg_pkg::*;
#(
  parameter int WIDTH = FG_PRESCALER_BITWIDTH
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             enable,
  input  logic [WIDTH-1:0] divisor,
  output logic             tick
);

  logic [WIDTH-1:0] count_q;

  assign tick = enable && (count_q == divisor);

  // Divider count 0..divisor; held at 0 while disabled so every run starts a fresh interval.
  // A divisor lowered below the current count restarts the interval instead of wrapping the counter.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      count_q <= '0;
    end else if (!enable || (count_q >= divisor)) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fg_wave_sequencer.sv
// rtl/fg_wave_sequencer.sv - waveform sequencer run control and config shadowing; FG_BURST_EN enables burst counting
module fg_wave_sequencer
  import fg_pkg::*;
#(
  parameter int COUNTER_BITWIDTH   = FG_COUNTER_BITWIDTH,
  parameter int WAVEFORM_BITWIDTH  = FG_WAVEFORM_BITWIDTH,
  parameter int PRESCALER_BITWIDTH = FG_PRESCALER_BITWIDTH,
  parameter int BURST_BITWIDTH     = FG_BURST_BITWIDTH
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          start_i,
  input  logic                          stop_i,
  input  logic [PRESCALER_BITWIDTH-1:0] prescale_i,
  input  logic                          cfg_valid_i,
  output logic                          cfg_ready_o,
  input  logic [COUNTER_BITWIDTH-1:0]   cfg_period_i,
  input  logic [COUNTER_BITWIDTH-1:0]   cfg_on_i,
  input  logic [WAVEFORM_BITWIDTH-1:0]  cfg_k_rise_i,
  input  logic [WAVEFORM_BITWIDTH-1:0]  cfg_k_fall_i,
  input  logic [WAVEFORM_BITWIDTH-1:0]  cfg_amplitude_i,
  input  logic [BURST_BITWIDTH-1:0]     cfg_bursts_i,
  output logic                          clk_en_o,
  output logic [COUNTER_BITWIDTH-1:0]   CR_o,
  output logic [COUNTER_BITWIDTH-1:0]   counter_o,
  output logic [COUNTER_BITWIDTH-1:0]   ON_counter_o,
  output logic [WAVEFORM_BITWIDTH-1:0]  k_rise_o,
  output logic [WAVEFORM_BITWIDTH-1:0]  k_fall_o,
  output logic [WAVEFORM_BITWIDTH-1:0]  amplitude_o,
  output logic                          busy_o,
  output logic                          done_o
);

  fg_state_e state_q, state_d;

  logic                         run_en;
  logic                         tick;
  logic                         wrap;
  logic                         commit;
  logic                         cfg_fire;
  logic                         enter_idle;
  logic                         burst_end;
  logic [COUNTER_BITWIDTH-1:0]  cr_q;
  logic [COUNTER_BITWIDTH-1:0]  on_clamped;
  logic                         shadow_full_q;
  logic [COUNTER_BITWIDTH-1:0]  sh_period_q;
  logic [COUNTER_BITWIDTH-1:0]  sh_on_q;
  logic [WAVEFORM_BITWIDTH-1:0] sh_k_rise_q;
  logic [WAVEFORM_BITWIDTH-1:0] sh_k_fall_q;
  logic [WAVEFORM_BITWIDTH-1:0] sh_amplitude_q;

  assign run_en = (state_q != IDLE);

  fg_tick_prescaler #(
    .WIDTH(PRESCALER_BITWIDTH)
  ) u_prescaler (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .enable  (run_en),
    .divisor (prescale_i),
    .tick    (tick)
  );

  assign clk_en_o    = tick;
  assign CR_o        = cr_q;
  assign wrap        = tick && (cr_q == counter_o);
  assign cfg_ready_o = !shadow_full_q;
  assign cfg_fire    = cfg_valid_i && !shadow_full_q;
  // Idle: commit the cycle after transfer. Running: only at a period boundary so a period never changes mid-way.
  assign commit      = shadow_full_q && (!run_en || wrap);
  assign on_clamped  = (cfg_on_i < cfg_period_i) ? cfg_on_i : cfg_period_i;

`ifdef FG_BURST_EN
  logic [BURST_BITWIDTH-1:0] sh_bursts_q;
  logic [BURST_BITWIDTH-1:0] bursts_act_q;
  logic [BURST_BITWIDTH-1:0] burst_left_q;

  // A loaded count of 0 never reaches 1, which is what makes bursts = 0 run continuously.
  assign burst_end = wrap && (burst_left_q == BURST_BITWIDTH'(1));

  // Burst shadow/active copy and remaining-period counter (loaded on the IDLE->RUN start).
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sh_bursts_q  <= '0;
      bursts_act_q <= '0;
      burst_left_q <= '0;
    end else begin
      if (cfg_fire) begin
        sh_bursts_q <= cfg_bursts_i;
      end
      if (commit) begin
        bursts_act_q <= sh_bursts_q;
      end
      if ((state_q == IDLE) && (state_d == RUN)) begin
        burst_left_q <= bursts_act_q;
      end else if (wrap && (burst_left_q != '0)) begin
        burst_left_q <= burst_left_q - BURST_BITWIDTH'(1);
      end
    end
  end
`else
  logic unused_bursts;
  assign unused_bursts = ^cfg_bursts_i;
  assign burst_end     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic plus busy and the enter-idle strobe that drives the done pulse.
  always_comb begin
    state_d    = state_q;
    busy_o     = run_en;
    enter_idle = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !stop_i) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (burst_end) begin
          state_d = IDLE;
        end else if (stop_i) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (start_i) begin
          state_d = RUN;
        end else if (wrap) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    enter_idle = run_en && (state_d == IDLE);
  end

  // Period counter and one-cycle completion pulse.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cr_q   <= '0;
      done_o <= 1'b0;
    end else begin
      done_o <= enter_idle;
      if (enter_idle || wrap) begin
        cr_q <= '0;
      end else if (tick) begin
        cr_q <= cr_q + COUNTER_BITWIDTH'(1);
      end
    end
  end

  // Pending shadow: filled by a handshake, emptied by commit (the two are mutually exclusive).
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      shadow_full_q  <= 1'b0;
      sh_period_q    <= '0;
      sh_on_q        <= '0;
      sh_k_rise_q    <= '0;
      sh_k_fall_q    <= '0;
      sh_amplitude_q <= '0;
    end else if (cfg_fire) begin
      shadow_full_q  <= 1'b1;
      sh_period_q    <= cfg_period_i;
      sh_on_q        <= on_clamped;
      sh_k_rise_q    <= cfg_k_rise_i;
      sh_k_fall_q    <= cfg_k_fall_i;
      sh_amplitude_q <= cfg_amplitude_i;
    end else if (commit) begin
      shadow_full_q  <= 1'b0;
    end
  end

  // Active configuration seen by the generator.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      counter_o    <= '0;
      ON_counter_o <= '0;
      k_rise_o     <= '0;
      k_fall_o     <= '0;
      amplitude_o  <= '0;
    end else if (commit) begin
      counter_o    <= sh_period_q;
      ON_counter_o <= sh_on_q;
      k_rise_o     <= sh_k_rise_q;
      k_fall_o     <= sh_k_fall_q;
      amplitude_o  <= sh_amplitude_q;
    end
  end

endmodule

// File: tb/tb_fg_wave_sequencer.sv
// tb/tb_fg_wave_sequencer.sv - scoreboard bench for fg_wave_sequencer
`timescale 1ns/1ps
module tb_fg_wave_sequencer;

  localparam int CB = 32;
  localparam int WB = 16;
  localparam int PB = 8;
  localparam int BB = 16;

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic          start_i = 1'b0;
  logic          stop_i = 1'b0;
  logic [PB-1:0] prescale_i = '0;
  logic          cfg_valid_i = 1'b0;
  logic          cfg_ready_o;
  logic [CB-1:0] cfg_period_i = '0;
  logic [CB-1:0] cfg_on_i = '0;
  logic [WB-1:0] cfg_k_rise_i = '0;
  logic [WB-1:0] cfg_k_fall_i = '0;
  logic [WB-1:0] cfg_amplitude_i = '0;
  logic [BB-1:0] cfg_bursts_i = '0;
  logic          clk_en_o;
  logic [CB-1:0] CR_o;
  logic [CB-1:0] counter_o;
  logic [CB-1:0] ON_counter_o;
  logic [WB-1:0] k_rise_o;
  logic [WB-1:0] k_fall_o;
  logic [WB-1:0] amplitude_o;
  logic          busy_o;
  logic          done_o;

  fg_wave_sequencer #(
    .COUNTER_BITWIDTH   (CB),
    .WAVEFORM_BITWIDTH  (WB),
    .PRESCALER_BITWIDTH (PB),
    .BURST_BITWIDTH     (BB)
  ) dut (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .start_i         (start_i),
    .stop_i          (stop_i),
    .prescale_i      (prescale_i),
    .cfg_valid_i     (cfg_valid_i),
    .cfg_ready_o     (cfg_ready_o),
    .cfg_period_i    (cfg_period_i),
    .cfg_on_i        (cfg_on_i),
    .cfg_k_rise_i    (cfg_k_rise_i),
    .cfg_k_fall_i    (cfg_k_fall_i),
    .cfg_amplitude_i (cfg_amplitude_i),
    .cfg_bursts_i    (cfg_bursts_i),
    .clk_en_o        (clk_en_o),
    .CR_o            (CR_o),
    .counter_o       (counter_o),
    .ON_counter_o    (ON_counter_o),
    .k_rise_o        (k_rise_o),
    .k_fall_o        (k_fall_o),
    .amplitude_o     (amplitude_o),
    .busy_o          (busy_o),
    .done_o          (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [CB-1:0] cr;
    logic [CB-1:0] per;
    logic [CB-1:0] on;
  } tick_t;

  tick_t exp_q[$];
  int    done_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    mon_ticks_en = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_period(input int per, input int on);
    tick_t t;
    for (int i = 0; i <= per; i++) begin
      t.cr  = CB'(i);
      t.per = CB'(per);
      t.on  = CB'(on);
      exp_q.push_back(t);
    end
  endtask

  task automatic set_cfg(input int per, input int on, input int kr, input int kf, input int amp, input int bursts);
    cfg_period_i    = CB'(per);
    cfg_on_i        = CB'(on);
    cfg_k_rise_i    = WB'(kr);
    cfg_k_fall_i    = WB'(kf);
    cfg_amplitude_i = WB'(amp);
    cfg_bursts_i    = BB'(bursts);
  endtask

  task automatic load_cfg(input int per, input int on, input int kr, input int kf, input int amp, input int bursts);
    @(posedge clk_i);
    #1;
    set_cfg(per, on, kr, kf, amp, bursts);
    cfg_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    cfg_valid_i = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk_i);
    #1 start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
  endtask

  task automatic pulse_stop();
    @(posedge clk_i);
    #1 stop_i = 1'b1;
    @(posedge clk_i);
    #1 stop_i = 1'b0;
  endtask

  task automatic wait_cr(input int v, input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while ((CR_o != CB'(v)) && (n < limit));
    chk("wait_cr_in_time", 64'(CR_o == CB'(v)), 64'd1);
  endtask

  task automatic wait_counter(input int v, input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while ((counter_o != CB'(v)) && (n < limit));
    chk("wait_counter_in_time", 64'(counter_o == CB'(v)), 64'd1);
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while ((busy_o || (exp_q.size() != 0) || (done_q.size() != 0)) && (n < limit)) begin
      @(negedge clk_i);
      n++;
    end
    chk("wait_idle_in_time", 64'(n < limit), 64'd1);
  endtask

  task automatic chk_quiet(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_i);
      chk("idle_clk_en", 64'(clk_en_o), 64'd0);
      chk("idle_busy", 64'(busy_o), 64'd0);
      chk("idle_cr", 64'(CR_o), 64'd0);
    end
  endtask

  initial begin : monitor
    tick_t e;
    forever begin
      @(negedge clk_i);
      if (clk_en_o && mon_ticks_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tick: got CR_o=%0d counter_o=%0d expected no tick", CR_o, counter_o);
        end else begin
          e = exp_q.pop_front();
          chk("tick_cr", 64'(CR_o), 64'(e.cr));
          chk("tick_period", 64'(counter_o), 64'(e.per));
          chk("tick_on", 64'(ON_counter_o), 64'(e.on));
        end
      end
      if (done_o) begin
        if (done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done_o=1 expected 0");
        end else begin
          void'(done_q.pop_front());
          chk("done_cr", 64'(CR_o), 64'd0);
          chk("done_busy", 64'(busy_o), 64'd0);
          chk("done_clk_en", 64'(clk_en_o), 64'd0);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    // reset state
    repeat (2) @(negedge clk_i);
    chk("rst_cr", 64'(CR_o), 64'd0);
    chk("rst_counter", 64'(counter_o), 64'd0);
    chk("rst_on", 64'(ON_counter_o), 64'd0);
    chk("rst_amp", 64'(amplitude_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_clk_en", 64'(clk_en_o), 64'd0);
    chk("rst_ready", 64'(cfg_ready_o), 64'd1);
    rstn_i = 1'b1;

    // idle commit one cycle after transfer; period 9 on 4, prescale 0
    load_cfg(9, 4, 'h11, 'h22, 'h300, 0);
    @(negedge clk_i);
    chk("idle_pend_ready", 64'(cfg_ready_o), 64'd0);
    chk("idle_pend_counter", 64'(counter_o), 64'd0);
    @(negedge clk_i);
    chk("idle_commit_counter", 64'(counter_o), 64'd9);
    chk("idle_commit_on", 64'(ON_counter_o), 64'd4);
    chk("idle_commit_krise", 64'(k_rise_o), 64'h11);
    chk("idle_commit_kfall", 64'(k_fall_o), 64'h22);
    chk("idle_commit_amp", 64'(amplitude_o), 64'h300);
    chk("idle_commit_ready", 64'(cfg_ready_o), 64'd1);

    prescale_i = '0;
    push_period(9, 4);
    push_period(9, 4);
    done_q.push_back(1);
    pulse_start();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_i);
      chk("p0_clk_en", 64'(clk_en_o), 64'd1);
      chk("p0_busy", 64'(busy_o), 64'd1);
    end
    pulse_stop();
    wait_idle(100);
    chk_quiet(2);

    // prescale 3: ticks on cycles 4, 8, 12 after start
    prescale_i = PB'(3);
    push_period(9, 4);
    done_q.push_back(1);
    pulse_start();
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk_i);
      chk("p3_clk_en", 64'(clk_en_o), 64'((k % 4) == 0));
      chk("p3_cr", 64'(CR_o), 64'((k - 1) / 4));
    end
    pulse_stop();
    wait_idle(200);

    // reconfigure mid-run: period 5, on 7 loaded at CR_o 3, commits at the wrap
    prescale_i = '0;
    push_period(9, 4);
    push_period(5, 5);
    done_q.push_back(1);
    pulse_start();
    wait_cr(3, 50);
    set_cfg(5, 7, 'h44, 'h55, 'h123, 0);
    cfg_valid_i = 1'b1;
    @(posedge clk_i);
    #1 cfg_valid_i = 1'b0;
    @(negedge clk_i);
    chk("run_pend_ready", 64'(cfg_ready_o), 64'd0);
    chk("run_pend_counter", 64'(counter_o), 64'd9);
    chk("run_pend_amp", 64'(amplitude_o), 64'h300);
    wait_counter(5, 50);
    chk("run_commit_cr", 64'(CR_o), 64'd0);
    chk("run_commit_ready", 64'(cfg_ready_o), 64'd1);
    chk("run_commit_on_clamp", 64'(ON_counter_o), 64'd5);
    chk("run_commit_amp", 64'(amplitude_o), 64'h123);
    stop_i = 1'b1;
    @(posedge clk_i);
    #1 stop_i = 1'b0;
    wait_idle(100);

    // stop at CR_o 2 of period 9
    load_cfg(9, 4, 'h11, 'h22, 'h300, 0);
    @(negedge clk_i);
    chk("reload_pend_counter", 64'(counter_o), 64'd5);
    @(negedge clk_i);
    chk("reload_counter", 64'(counter_o), 64'd9);
    push_period(9, 4);
    done_q.push_back(1);
    pulse_start();
    wait_cr(2, 50);
    stop_i = 1'b1;
    @(posedge clk_i);
    #1 stop_i = 1'b0;
    wait_idle(100);
    chk_quiet(3);

    // start+stop together: ignored in IDLE, drains in RUN
    @(posedge clk_i);
    #1;
    start_i = 1'b1;
    stop_i  = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    stop_i  = 1'b0;
    chk_quiet(3);
    push_period(9, 4);
    done_q.push_back(1);
    pulse_start();
    wait_cr(4, 50);
    start_i = 1'b1;
    stop_i  = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    stop_i  = 1'b0;
    wait_idle(100);

    // period 0: CR_o held at 0, wrap every tick, ON clamped to 0
    load_cfg(0, 3, 'h11, 'h22, 'h300, 0);
    repeat (2) @(negedge clk_i);
    chk("p_zero_counter", 64'(counter_o), 64'd0);
    chk("p_zero_on", 64'(ON_counter_o), 64'd0);
    for (int i = 0; i < 3; i++) push_period(0, 0);
    done_q.push_back(1);
    pulse_start();
    pulse_stop();
    wait_idle(50);

`ifdef FG_BURST_EN
    // 3 bursts of period 4: exactly 15 ticks then IDLE
    load_cfg(4, 2, 'h11, 'h22, 'h300, 3);
    repeat (2) @(negedge clk_i);
    for (int i = 0; i < 3; i++) push_period(4, 2);
    done_q.push_back(1);
    pulse_start();
    wait_idle(100);
    chk_quiet(2);

    // bursts 0: still running after 100 periods
    load_cfg(4, 2, 'h11, 'h22, 'h300, 0);
    repeat (2) @(negedge clk_i);
    for (int i = 0; i < 101; i++) push_period(4, 2);
    pulse_start();
    begin
      int n;
      n = 0;
      while ((exp_q.size() > 5) && (n < 1000)) begin
        @(negedge clk_i);
        n++;
      end
      chk("cont_in_time", 64'(n < 1000), 64'd1);
    end
    mon_ticks_en = 1'b0;
    exp_q.delete();
    chk("cont_busy", 64'(busy_o), 64'd1);
    done_q.push_back(1);
    pulse_stop();
    wait_idle(50);
    mon_ticks_en = 1'b1;
`endif

    // reset mid-run with pending config
    load_cfg(9, 4, 'h11, 'h22, 'h300, 0);
    repeat (2) @(negedge clk_i);
    mon_ticks_en = 1'b0;
    pulse_start();
    repeat (5) @(negedge clk_i);
    set_cfg(3, 1, 'h66, 'h77, 'h88, 0);
    cfg_valid_i = 1'b1;
    @(posedge clk_i);
    #1 cfg_valid_i = 1'b0;
    @(negedge clk_i);
    chk("mid_pend_ready", 64'(cfg_ready_o), 64'd0);
    chk("mid_busy", 64'(busy_o), 64'd1);
    #2 rstn_i = 1'b0;
    #1;
    chk("arst_cr", 64'(CR_o), 64'd0);
    chk("arst_counter", 64'(counter_o), 64'd0);
    chk("arst_on", 64'(ON_counter_o), 64'd0);
    chk("arst_krise", 64'(k_rise_o), 64'd0);
    chk("arst_kfall", 64'(k_fall_o), 64'd0);
    chk("arst_amp", 64'(amplitude_o), 64'd0);
    chk("arst_busy", 64'(busy_o), 64'd0);
    chk("arst_done", 64'(done_o), 64'd0);
    chk("arst_clk_en", 64'(clk_en_o), 64'd0);
    chk("arst_ready", 64'(cfg_ready_o), 64'd1);
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      chk("post_rst_counter", 64'(counter_o), 64'd0);
      chk("post_rst_busy", 64'(busy_o), 64'd0);
      chk("post_rst_ready", 64'(cfg_ready_o), 64'd1);
    end
    mon_ticks_en = 1'b1;
    chk("queues_drained", 64'(exp_q.size() + done_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
